// File: rtl/upsampler_v_nearest_fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module : upsampler_v_nearest_fp16_pkg
// Brief  : Shared dfdd fp16 pixel, coordinate and upsampler state types.
// Rev    : 1.0  initial release
// ============================================================================
package upsampler_v_nearest_fp16_pkg;

    localparam int c_FP16_EXP_WIDTH  = 5;
    localparam int c_FP16_FRAC_WIDTH = 10;

    typedef struct packed {
        logic                         sign;
        logic [c_FP16_EXP_WIDTH-1:0]  exp;
        logic [c_FP16_FRAC_WIDTH-1:0] frac;
    } fp16_t;

    typedef logic [15:0] coord_t;

    typedef enum logic [0:0] {
        PASS   = 1'b0,
        REPLAY = 1'b1
    } ups_state_t;

endpackage : upsampler_v_nearest_fp16_pkg
`default_nettype wire

// File: rtl/upsampler_line_buffer.sv
`default_nettype none
// ============================================================================
// Module : upsampler_line_buffer
// Brief  : Simple dual-port RAM, one write port, registered read port.
// Rev    : 1.0  initial release
// ============================================================================
module upsampler_line_buffer #(
    parameter int DEPTH      = 640,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : upsampler_line_buffer
`default_nettype wire

// File: rtl/upsampler_v_nearest_fp16.sv
`default_nettype none
// ============================================================================
// Module : upsampler_v_nearest_fp16
// Brief  : Vertical 2x nearest upsampler; each row is passed, then replayed.
// Rev    : 1.0  initial release
// ============================================================================
module upsampler_v_nearest_fp16
    import upsampler_v_nearest_fp16_pkg::*;
#(
    parameter  int EXP_WIDTH    = 5,
    parameter  int FRAC_WIDTH   = 10,
    parameter  int IMAGE_WIDTH  = 640,
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
    localparam int ADDR_WIDTH   = $clog2(IMAGE_WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] data_i,
    input  logic [15:0]             col_i,
    input  logic [15:0]             row_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [FP_WIDTH_REG-1:0] data_o,
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    valid_o
);

    localparam coord_t                c_WIDTH_COORD = coord_t'(IMAGE_WIDTH);
    localparam coord_t                c_LAST_COL    = coord_t'(IMAGE_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR   = ADDR_WIDTH'(IMAGE_WIDTH - 1);

    ups_state_t              r_state;
    logic                    r_ready;
    logic                    r_valid;
    logic                    r_sel_rep;
    logic [FP_WIDTH_REG-1:0] r_data;
    coord_t                  r_col;
    coord_t                  r_row;
    logic [14:0]             r_saved_row_lsbs;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;

    logic                    w_xfer;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic [FP_WIDTH_REG-1:0] w_rd_data;
    logic                    w_unused_row_msb;

    // Output row numbers wrap, so the top input row bit never matters.
    assign w_unused_row_msb = row_i[15];

    assign w_xfer  = valid_i && r_ready;
    assign w_wr_en = w_xfer && (col_i < c_WIDTH_COORD);
    assign w_rd_en = (r_state == REPLAY);

    upsampler_line_buffer #(
        .DEPTH      (IMAGE_WIDTH),
        .WIDTH      (FP_WIDTH_REG),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_line_buffer (
        .clk       (clk_i),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (col_i[ADDR_WIDTH-1:0]),
        .i_wr_data (data_i),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state          <= PASS;
            r_ready          <= 1'b1;
            r_valid          <= 1'b0;
            r_sel_rep        <= 1'b0;
            r_data           <= '0;
            r_col            <= '0;
            r_row            <= '0;
            r_saved_row_lsbs <= '0;
            r_rd_addr        <= '0;
        end else begin
            case (r_state)
                PASS: begin
                    r_sel_rep <= 1'b0;
                    r_valid   <= w_xfer;
                    if (w_xfer) begin
                        r_data           <= data_i;
                        r_col            <= col_i;
                        r_row            <= {row_i[14:0], 1'b0};
                        r_saved_row_lsbs <= row_i[14:0];
                        if (col_i == c_LAST_COL) begin
                            r_state   <= REPLAY;
                            r_ready   <= 1'b0;
                            r_rd_addr <= '0;
                        end
                    end
                end
                REPLAY: begin
                    // Coordinates lag the RAM read by one cycle to line up with its registered output.
                    r_sel_rep <= 1'b1;
                    r_valid   <= 1'b1;
                    r_col     <= coord_t'(r_rd_addr);
                    r_row     <= {r_saved_row_lsbs, 1'b1};
                    if (r_rd_addr == c_LAST_ADDR) begin
                        r_state <= PASS;
                        r_ready <= 1'b1;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                default: begin
                    r_state <= PASS;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign data_o  = r_sel_rep ? w_rd_data : r_data;
    assign col_o   = r_col;
    assign row_o   = r_row;

endmodule : upsampler_v_nearest_fp16
`default_nettype wire

// File: doc/upsampler_v_nearest_fp16.md
Name: upsampler_v_nearest_fp16

Overview:
- Vertical 2x nearest-neighbour upsampler for the fp16 pixel stream; the inverse-direction partner of the vertical 2:1 averaging downsampler in the dfdd pyramid.
- Each input row r is emitted twice: once as output row 2r (pass-through) and once as output row 2r+1 (replayed from an internal line buffer).
- Sits between a coarse pyramid level and the next finer-level consumer.
- Adds a ready_o back-pressure output because the output row count is twice the input row count.

Parameters:
- EXP_WIDTH, 5, fp exponent width.
- FRAC_WIDTH, 10, fp fraction width.
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, pixel word width (local).
- IMAGE_WIDTH, 640, pixels per input row; line buffer depth.
- ADDR_WIDTH, $clog2(IMAGE_WIDTH), line buffer address width (local).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-low (low = reset).
- data_i  in  FP_WIDTH_REG  input pixel.
- col_i  in  16  input column.
- row_i  in  16  input row.
- valid_i  in  1  input pixel valid.
- ready_o  out  1  block accepts a pixel this cycle. Transfer occurs when valid_i && ready_o.
- data_o  out  FP_WIDTH_REG  output pixel.
- col_o  out  16  output column.
- row_o  out  16  output row.
- valid_o  out  1  output pixel valid.

Behaviour:
- Reset (rst_i==0 at a clock edge):
  - state=PASS.
  - valid_o=0, data_o=0, col_o=0, row_o=0.
  - ready_o=1 after reset.
  - Line buffer contents are not cleared.
- PASS state, ready_o=1:
  - On each transfer at cycle t:
    - Cycle t+1: data_o=data_i, col_o=col_i, row_o={row_i[14:0],1'b0}, valid_o=1.
    - Write data_i to line buffer at address col_i. The write is suppressed if col_i >= IMAGE_WIDTH; the pixel is still passed through.
    - Latch row_i into saved_row.
  - Cycles with no transfer: valid_o=0 next cycle.
- End of row: a transfer with col_i==IMAGE_WIDTH-1 at cycle t moves state to REPLAY at t+1. ready_o is registered, so it is 0 during cycles t+1..t+IMAGE_WIDTH.
- REPLAY state, IMAGE_WIDTH cycles:
  - Read address k is issued at cycle t+1+k, for k = 0..IMAGE_WIDTH-1.
  - Registered read data appears at cycle t+2+k: data_o=buffer[k], col_o=k, row_o={saved_row[14:0],1'b1}, valid_o=1.
  - After the last read issue, state returns to PASS at t+IMAGE_WIDTH+1 with ready_o=1.
  - A transfer accepted at t+IMAGE_WIDTH+1 appears at t+IMAGE_WIDTH+2, so there is no output collision.
- valid_i asserted while ready_o=0: no transfer. Upstream must hold data, col and row stable.
- Row numbering: row_o wraps by truncation for row_i >= 32768. No other checks are made.
- Last input row: replayed like any other row. No edge extension beyond the duplicate.
- Incomplete rows (col_i never reaches IMAGE_WIDTH-1): no replay. The next row overwrites the buffer.
- Reset mid-REPLAY: replay is aborted, valid_o=0 next cycle, state=PASS.
- Latency: 1 cycle for pass-through pixels; 2 to IMAGE_WIDTH+1 cycles after the row-end transfer for replayed pixels.
- Throughput: at most IMAGE_WIDTH input pixels per 2*IMAGE_WIDTH cycles.

Decomposition:
- Shared package (dfdd fp package):
  - fp16 pixel typedef (sign/exp/frac struct).
  - 16-bit coord typedef.
  - upsampler state enum {PASS, REPLAY}.
- Sub-module upsampler_line_buffer: simple dual-port RAM.
  - One write port; one read port with registered output.
  - Depth IMAGE_WIDTH, width FP_WIDTH_REG.
  - Infers BRAM.
- The top level holds the FSM, replay counter, saved_row and output registers.

Test Plan:
- IMAGE_WIDTH=4. Stream row 0 = {0x3C00,0x4000,0x4200,0x4400}, valid_i held high.
  -> Outputs row 0 cols 0..3 with those values, then row 1 cols 0..3 with the same values.
  -> ready_o low for exactly 4 cycles after the col=3 transfer.
- Rows 0..2 streamed back-to-back with valid_i high, honouring ready_o.
  -> Output rows 0,1,2,3,4,5 in order, 24 valid pixels, no gaps beyond the 1-cycle latency.
  -> Each odd row equals the preceding even row.
- valid_i high with new data during REPLAY.
  -> The data is not consumed and buffer replay values are unchanged.
  -> The held pixel is accepted in the first PASS cycle and appears 1 cycle later.
- rst_i=0 asserted on the 2nd replay cycle.
  -> valid_o=0 from the next cycle, ready_o=1 after reset.
  -> A subsequent row 5 outputs rows 10 and 11 correctly.
- row_i=0x8001, 4 pixels.
  -> row_o=0x0002 for pass-through and 0x0003 for replay (truncating wrap).
- Pixel with col_i=6 (>= IMAGE_WIDTH) within a row.
  -> Passed through with col_o=6.
  -> The buffer is not written; the replay of cols 0..3 is unaffected.
